// File: rtl/line_buffer_pkg.sv
// Shared definitions for the line_buffer delay line: pointer sizing and reset value.
package line_buffer_pkg;

  localparam logic LB_RESET_VALUE = '0;

  // A depth of 1 still needs a 1-bit pointer so the port never collapses to zero width.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/lb_wrap_counter.sv
// Modulo-MAX counter (0..MAX-1) used as the circular-buffer pointer of line_buffer.
module lb_wrap_counter
  import line_buffer_pkg::*;
#(
  parameter  int MAX = 10,
  localparam int W   = ptr_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Explicit compare so non-power-of-two MAX wraps correctly.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == W'(MAX - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_buffer.sv
// Fixed delay line: y_out reproduces x_in exactly DEPTH_SIZE cycles later via a circular buffer.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int DEPTH_SIZE = 10,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0] y_out
);

  localparam int PTR_W = ptr_width(DEPTH_SIZE);

  if (DEPTH_SIZE < 1 || DEPTH_SIZE > 1024) begin : g_bad_depth
    $error("line_buffer: DEPTH_SIZE must be in 1..1024");
  end

  logic [PTR_W-1:0]      ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH_SIZE];

  lb_wrap_counter #(
    .MAX (DEPTH_SIZE)
  ) u_ptr (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .cnt (ptr)
  );

  // Read-before-write at the same slot: the entry being overwritten is the one
  // written DEPTH_SIZE cycles ago, which is exactly the sample to emit.
  // NOTE: the array is held in flops with an async clear so stale history never leaks out after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_out <= {DATA_WIDTH{LB_RESET_VALUE}};
      for (int i = 0; i < DEPTH_SIZE; i++) begin
        mem[i] <= {DATA_WIDTH{LB_RESET_VALUE}};
      end
    end else begin
      y_out    <= mem[ptr];
      mem[ptr] <= x_in;
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer at depths 10, 5 and 1 using per-instance scoreboard queues.
module tb_line_buffer;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        x10, y10;
  logic [15:0] x5, y5;
  logic        x1, y1;

  logic [15:0] q10[$];
  logic [15:0] q5[$];
  logic [15:0] q1[$];

  int passed;
  int total;

  line_buffer #(.DEPTH_SIZE(10), .DATA_WIDTH(1)) u_d10 (
    .clk (clk), .rst (rst_n), .x_in (x10), .y_out (y10)
  );
  line_buffer #(.DEPTH_SIZE(5), .DATA_WIDTH(16)) u_d5 (
    .clk (clk), .rst (rst_n), .x_in (x5), .y_out (y5)
  );
  line_buffer #(.DEPTH_SIZE(1), .DATA_WIDTH(1)) u_d1 (
    .clk (clk), .rst (rst_n), .x_in (x1), .y_out (y1)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // After reset each instance must emit exactly DEPTH zeros before real data.
  task automatic refill();
    q10.delete(); q5.delete(); q1.delete();
    repeat (10) q10.push_back(16'h0);
    repeat (5)  q5.push_back(16'h0);
    q1.push_back(16'h0);
  endtask

  // Drive current inputs, clock once, then compare every output against its scoreboard.
  task automatic step(input string tag);
    q10.push_back({15'h0, x10});
    q5.push_back(x5);
    q1.push_back({15'h0, x1});
    @(posedge clk);
    #1;
    check({tag, "_d10"}, {15'h0, y10}, q10.pop_front());
    check({tag, "_d5"},  y5,           q5.pop_front());
    check({tag, "_d1"},  {15'h0, y1},  q1.pop_front());
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_async_d10"}, {15'h0, y10}, 16'h0);
    check({tag, "_async_d5"},  y5,           16'h0);
    check({tag, "_async_d1"},  {15'h0, y1},  16'h0);
    #2 rst_n = 1'b1;
    refill();
  endtask

  logic [7:0] lfsr;
  logic [9:0] basic_pat;

  initial begin
    passed = 0;
    total  = 0;
    clk_en = 1'b0;
    x10 = 1'b0; x5 = 16'h0; x1 = 1'b0;
    basic_pat = 10'b11_0100_1101;  // bit i is the sample driven on edge i

    // Power-up: reset pulse before any clock edge.
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #3;
    check("pwr_d10", {15'h0, y10}, 16'h0);
    check("pwr_d5",  y5,           16'h0);
    check("pwr_d1",  {15'h0, y1},  16'h0);
    rst_n = 1'b1;
    refill();
    #3 clk_en = 1'b1;

    // Basic delay (d10), 0xA001.. sequence (d5), toggling input (d1).
    for (int i = 0; i < 20; i++) begin
      x10 = (i < 10) ? basic_pat[i] : 1'b0;
      x5  = (i < 12) ? 16'hA001 + 16'(i) : 16'h0;
      x1  = ~x1;
      step("basic");
    end

    // Wrap-around: 40 LFSR samples spanning several pointer wraps.
    lfsr = 8'hB5;
    for (int i = 0; i < 40; i++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      x10  = lfsr[0];
      x5   = {lfsr, ~lfsr};
      x1   = lfsr[1];
      step("wrap");
    end

    // Mid-stream reset: buffer full of ones must not leak out after release.
    for (int i = 0; i < 15; i++) begin
      x10 = 1'b1; x5 = 16'hFFFF; x1 = 1'b1;
      step("ones");
    end
    pulse_reset("mid");
    for (int i = 0; i < 16; i++) begin
      x10 = (i >= 12) ? i[0] : 1'b1;
      x5  = (i >= 12) ? 16'h1234 + 16'(i) : 16'hFFFF;
      x1  = i[0];
      step("post");
    end

    // Unknowns are carried through, not masked.
    x5 = 16'hxxxx; x10 = 1'b0; x1 = 1'b0;
    step("xin");
    x5 = 16'h0;
    repeat (6) step("xout");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
# line_buffer

Fixed-length delay line that reproduces its input stream exactly DEPTH_SIZE clock cycles later. It sits in the image/stream datapath where a full line of samples must be held so that the current sample can be aligned with the sample one line earlier. Storage is a circular buffer of DEPTH_SIZE entries with a single wrapping pointer. The output is registered.

## Interface
- DEPTH_SIZE, default 10: delay in clock cycles, which is also the number of stored entries; legal range 1..1024.
- DATA_WIDTH, default 1: width of each sample in bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all state while low.
- x_in  input  DATA_WIDTH  sample written every cycle; there is no valid/enable.
- y_out  output  DATA_WIDTH  sample from DEPTH_SIZE cycles ago; registered.

## Operation
- Storage is mem[0..DEPTH_SIZE-1] of DATA_WIDTH bits, plus a pointer ptr of width PTR_W = max(1, $clog2(DEPTH_SIZE)).
- Each rising edge with rst high performs all of the following at once:
  - y_out <= mem[ptr], the old contents, read before the write;
  - mem[ptr] <= x_in;
  - ptr <= (ptr == DEPTH_SIZE-1) ? 0 : ptr+1.
- Wrap-around is an explicit compare, not a power-of-two overflow, so any DEPTH_SIZE is supported.
- DEPTH_SIZE == 1:
  - ptr stays at 0;
  - the block behaves as a 2-stage register chain, giving a 1-cycle delay.
- The buffer is always "full": there is no back-pressure and no stall.
- Reset (rst low, at any time, including mid-stream):
  - y_out = 0, ptr = 0, and every mem entry = 0 immediately, without waiting for clk;
  - stream history is discarded.
- After reset releases, the first DEPTH_SIZE outputs are 0 (fill phase). The output is the delayed input from then on.
- X on x_in propagates to y_out unchanged after DEPTH_SIZE cycles. No X-masking.

## Timing
- Latency: the value on x_in sampled at edge k appears on y_out just after edge k+DEPTH_SIZE and holds until edge k+DEPTH_SIZE+1.
- Throughput: one sample per clock.
- Reset assertion is asynchronous and outputs clear combinationally from rst.
- Reset deassertion is synchronised by the system. The first edge with rst high counts as edge 0 of the fill phase.
- There is no combinational path from x_in to y_out.

## Structure
- Shared package line_buffer_pkg holds:
  - the function ptr_width(depth), which returns max(1, $clog2(depth));
  - the constant LB_RESET_VALUE = '0.
- One sub-module, lb_wrap_counter #(MAX), handles the pointer:
  - ports clk, rst, inc, cnt;
  - counts 0..MAX-1 and wraps;
  - async active-low reset to 0.
- Top level contains:
  - the register array, so that an asynchronous clear is possible;
  - the output register;
  - the counter, with inc tied high.
- Elaboration-time assertion: DEPTH_SIZE >= 1.

## Test plan
- Basic delay, DEPTH_SIZE=10, DATA_WIDTH=1:
  - stimulus: drive 1,0,1,1,0,0,1,0,1,1 on edges 0..9, then zeros;
  - required response: y_out is 0 after edges 0..9, then after edges 10..19 shows 1,0,1,1,0,0,1,0,1,1.
- Wrap-around, DEPTH_SIZE=10:
  - stimulus: stream 40 cycles of an LFSR pattern;
  - required response: y_out(t) == x_in(t-10) for every t >= 10, across 3 pointer wraps.
- Non-power-of-two depth, DEPTH_SIZE=5, DATA_WIDTH=16:
  - stimulus: inputs 0xA001..0xA00C;
  - required response: 0 for 5 cycles, then 0xA001..0xA007 with exact 5-cycle latency.
- Depth 1, DEPTH_SIZE=1:
  - stimulus: input toggles every cycle;
  - required response: y_out equals the previous cycle's input.
- Mid-stream reset, DEPTH_SIZE=10:
  - stimulus: after 15 cycles of all-ones, pulse rst low between clock edges;
  - required response: y_out goes to 0 during the pulse, and stays 0 for 10 cycles after release even though the old ones were in the buffer;
  - then the new stream follows.
- Power-up:
  - stimulus: rst sequence 1→0→1 before clocking starts;
  - required response: y_out = 0 and no X on y_out during the first DEPTH_SIZE cycles.
